// File: rtl/tx_pipe_block_framer.sv
// TX PIPE block framer: registers scrambler output onto the PIPE TX bus and frames 128b/130b blocks.
// Optional block counter output enabled by defining TX_FRAMER_BLOCK_STATS_EN.
module tx_pipe_block_framer #(
  parameter int SYMS_PER_BLOCK = 16,
  parameter int STAT_W         = 16
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [2:0]  GEN,
  input  logic [5:0]  PIPEWIDTH,
  input  logic [31:0] scramblerDataOut,
  input  logic [3:0]  scramblerDataK,
  input  logic        scramblerDataValid,
  input  logic [1:0]  scramblerSyncHeader,
  output logic [31:0] TxData,
  output logic [3:0]  TxDataK,
  output logic        TxDataValid,
  output logic        TxStartBlock,
  output logic [1:0]  TxSyncHeader,
  output logic        headerErr
`ifdef TX_FRAMER_BLOCK_STATS_EN
  ,
  output logic [STAT_W-1:0] blockCount
`endif
);

  localparam int CNT_W = $clog2(SYMS_PER_BLOCK + 1);

  localparam logic [1:0] LEGACY   = 2'd0;
  localparam logic [1:0] BLK_IDLE = 2'd1;
  localparam logic [1:0] BLK_BODY = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_eff;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_sum;
  logic [CNT_W-1:0] bpb;
  logic [5:0]       width_q;
  logic [31:0]      width_mask;
  logic             gen3;
  logic             width_ok;
  logic             mode_chg;
  logic             blk_done;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    gen3       = (GEN >= 3'd3);
    width_ok   = 1'b1;
    bpb        = '0;
    width_mask = '0;
    case (PIPEWIDTH)
      6'd8:  begin bpb = CNT_W'(1); width_mask = 32'h0000_00FF; end
      6'd16: begin bpb = CNT_W'(2); width_mask = 32'h0000_FFFF; end
      6'd32: begin bpb = CNT_W'(4); width_mask = 32'hFFFF_FFFF; end
      default: width_ok = 1'b0;
    endcase

    // A width change or a GEN crossing abandons any partial block and restarts framing from idle.
    mode_chg  = (PIPEWIDTH != width_q) || (gen3 == (state == LEGACY));
    state_eff = !gen3 ? LEGACY : (mode_chg ? BLK_IDLE : state);
    cnt_base  = mode_chg ? '0 : count;
    cnt_sum   = cnt_base + bpb;

    blk_done = 1'b0;
    if (gen3 && width_ok && scramblerDataValid) begin
      if (state_eff == BLK_IDLE) blk_done = (bpb == CNT_W'(SYMS_PER_BLOCK));
      else                       blk_done = (cnt_sum >= CNT_W'(SYMS_PER_BLOCK));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge pclk) begin
    if (reset) begin
      TxData       <= '0;
      TxDataK      <= '0;
      TxDataValid  <= 1'b0;
      TxStartBlock <= 1'b0;
      TxSyncHeader <= 2'b00;
      headerErr    <= 1'b0;
      count        <= '0;
      width_q      <= PIPEWIDTH;
      state        <= (GEN >= 3'd3) ? BLK_IDLE : LEGACY;
    end else begin
      width_q      <= PIPEWIDTH;
      TxData       <= '0;
      TxDataK      <= '0;
      TxDataValid  <= 1'b0;
      TxStartBlock <= 1'b0;
      headerErr    <= 1'b0;
      count        <= '0;
      state        <= gen3 ? BLK_IDLE : LEGACY;

      if (!width_ok) begin
        TxSyncHeader <= 2'b00;
      end else if (!gen3) begin
        TxSyncHeader <= 2'b00;
        if (scramblerDataValid) begin
          TxData      <= scramblerDataOut;
          TxDataK     <= scramblerDataK;
          TxDataValid <= 1'b1;
        end
      end else begin
        state <= state_eff;
        count <= cnt_base;
        if (scramblerDataValid) begin
          TxData      <= scramblerDataOut & width_mask;
          TxDataValid <= 1'b1;
          if (state_eff == BLK_IDLE) begin
            // Illegal headers still open the block; the violation is only flagged.
            TxStartBlock <= 1'b1;
            TxSyncHeader <= scramblerSyncHeader;
            headerErr    <= (scramblerSyncHeader[1] ~^ scramblerSyncHeader[0]);
            count        <= blk_done ? '0 : bpb;
            state        <= blk_done ? BLK_IDLE : BLK_BODY;
          end else begin
            headerErr <= (scramblerSyncHeader != TxSyncHeader);
            count     <= blk_done ? '0 : cnt_sum;
            state     <= blk_done ? BLK_IDLE : BLK_BODY;
          end
        end
      end
    end
  end

`ifdef TX_FRAMER_BLOCK_STATS_EN
  always_ff @(posedge pclk) begin
    if (reset || !gen3) begin
      blockCount <= '0;
    end else if (blk_done && (blockCount != {STAT_W{1'b1}})) begin
      blockCount <= blockCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_pipe_block_framer.sv
// Randomized self-checking bench for tx_pipe_block_framer against a symbol-count reference model.
// Checks blockCount as well when TX_FRAMER_BLOCK_STATS_EN is defined.
module tb_tx_pipe_block_framer;

  localparam int SYMS   = 16;
  localparam int STAT_W = 16;

  logic        pclk = 1'b0;
  logic        reset;
  logic [2:0]  GEN;
  logic [5:0]  PIPEWIDTH;
  logic [31:0] scramblerDataOut;
  logic [3:0]  scramblerDataK;
  logic        scramblerDataValid;
  logic [1:0]  scramblerSyncHeader;
  logic [31:0] TxData;
  logic [3:0]  TxDataK;
  logic        TxDataValid;
  logic        TxStartBlock;
  logic [1:0]  TxSyncHeader;
  logic        headerErr;
`ifdef TX_FRAMER_BLOCK_STATS_EN
  logic [STAT_W-1:0] blockCount;
`endif

  tx_pipe_block_framer #(.SYMS_PER_BLOCK(SYMS), .STAT_W(STAT_W)) dut (
    .pclk                (pclk),
    .reset               (reset),
    .GEN                 (GEN),
    .PIPEWIDTH           (PIPEWIDTH),
    .scramblerDataOut    (scramblerDataOut),
    .scramblerDataK      (scramblerDataK),
    .scramblerDataValid  (scramblerDataValid),
    .scramblerSyncHeader (scramblerSyncHeader),
    .TxData              (TxData),
    .TxDataK             (TxDataK),
    .TxDataValid         (TxDataValid),
    .TxStartBlock        (TxStartBlock),
    .TxSyncHeader        (TxSyncHeader),
    .headerErr           (headerErr)
`ifdef TX_FRAMER_BLOCK_STATS_EN
    ,
    .blockCount          (blockCount)
`endif
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  // Reference model: symbols already sent in the open block (0 = waiting for a block start).
  int         fill = 0;
  logic [1:0] hdr_m = 2'b00;
  int         blocks = 0;
  int         last_w = 0;
  bit         last_g3 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input logic [2:0] g, input int w, input logic [31:0] d,
                      input logic [3:0] k, input bit v, input logic [1:0] h);
    bit          g3;
    bit          legal;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    bit          e_v;
    bit          e_sb;
    bit          e_err;
    logic [1:0]  e_hdr;

    reset = r; GEN = g; PIPEWIDTH = 6'(w);
    scramblerDataOut = d; scramblerDataK = k; scramblerDataValid = v; scramblerSyncHeader = h;

    g3 = (g >= 3); legal = (w == 8 || w == 16 || w == 32);
    e_data = '0; e_k = '0; e_v = 0; e_sb = 0; e_err = 0;
    if (r) begin
      fill = 0; hdr_m = 2'b00; blocks = 0;
    end else begin
      if (g3 != last_g3 || w != last_w) fill = 0;
      if (!g3) blocks = 0;
      if (!legal) begin
        fill = 0; hdr_m = 2'b00;
      end else if (!g3) begin
        hdr_m = 2'b00;
        if (v) begin e_data = d; e_k = k; e_v = 1; end
      end else if (v) begin
        e_v = 1;
        e_data = (w == 32) ? d : (d & ((32'd1 << w) - 32'd1));
        if (fill == 0) begin
          e_sb = 1; e_err = (h == 2'b00 || h == 2'b11); hdr_m = h;
        end else begin
          e_err = (h != hdr_m);
        end
        fill += w / 8;
        if (fill >= SYMS) begin
          fill = 0;
          if (blocks < (1 << STAT_W) - 1) blocks++;
        end
      end
    end
    last_g3 = g3; last_w = w;
    e_hdr = hdr_m;

    @(posedge pclk); #1;
    check("TxData", TxData, e_data);
    check("TxDataK", 32'(TxDataK), 32'(e_k));
    check("TxDataValid", 32'(TxDataValid), 32'(e_v));
    check("TxStartBlock", 32'(TxStartBlock), 32'(e_sb));
    check("TxSyncHeader", 32'(TxSyncHeader), 32'(e_hdr));
    check("headerErr", 32'(headerErr), 32'(e_err));
`ifdef TX_FRAMER_BLOCK_STATS_EN
    check("blockCount", 32'(blockCount), 32'(blocks));
`endif
    if (TxStartBlock === 1'b1) n_starts++;
    @(negedge pclk);
  endtask

  initial begin
    int beats;
    int w;
    logic [2:0] g;
    logic [1:0] ph;
    logic [1:0] h;
    int widths[5] = '{8, 16, 32, 24, 0};

    @(negedge pclk);
    step(1, 3'd1, 32, '0, '0, 0, 2'b00);
    step(1, 3'd1, 32, '0, '0, 0, 2'b00);

    // Gen1 pass-through
    step(0, 3'd1, 32, 32'hFDBABAFB, 4'b1001, 1, 2'b00);
    check("gen1_data", TxData, 32'hFDBABAFB);

    // Gen3 x32: starts on beats 1 and 5 of 8
    step(0, 3'd3, 32, '0, '0, 0, 2'b01);
    n_starts = 0;
    for (int i = 0; i < 8; i++) step(0, 3'd3, 32, $urandom, 4'hF, 1, 2'b01);
    check("starts_x32", 32'(n_starts), 32'd2);

    // Gen3 x8 with gaps: one start over 16 valid beats, 17th starts again
    step(0, 3'd3, 8, '0, '0, 0, 2'b10);
    n_starts = 0;
    beats = 0;
    for (int c = 0; beats < 16; c++) begin
      if (c % 3 == 2) step(0, 3'd3, 8, $urandom, '0, 0, 2'b10);
      else begin step(0, 3'd3, 8, $urandom, '0, 1, 2'b10); beats++; end
    end
    check("starts_x8", 32'(n_starts), 32'd1);
    step(0, 3'd3, 8, $urandom, '0, 1, 2'b10);
    check("restart_x8", 32'(TxStartBlock), 32'd1);

    // Gen3 x16 header violation on beat 4
    step(0, 3'd3, 16, '0, '0, 0, 2'b01);
    for (int i = 1; i <= 8; i++) step(0, 3'd3, 16, $urandom, '0, 1, (i == 4) ? 2'b10 : 2'b01);

    // Reset mid-block
    step(0, 3'd3, 32, $urandom, '0, 1, 2'b01);
    step(0, 3'd3, 32, $urandom, '0, 1, 2'b01);
    step(1, 3'd3, 32, $urandom, '0, 1, 2'b01);
    step(0, 3'd3, 32, $urandom, '0, 1, 2'b10);
    check("start_after_reset", 32'(TxStartBlock), 32'd1);

    // Illegal width, then 12 x32 beats (3 blocks)
    for (int i = 0; i < 4; i++) step(0, 3'd3, 24, $urandom, '0, 1, 2'b01);
    for (int i = 0; i < 12; i++) step(0, 3'd3, 32, $urandom, '0, 1, 2'b01);

    // Random phases; configuration only changes on a non-valid beat
    for (int p = 0; p < 40; p++) begin
      g  = 3'($urandom_range(1, 7));
      w  = widths[$urandom_range(0, 4)];
      ph = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'($urandom_range(1, 2));
      step(0, g, w, $urandom, 4'($urandom), 0, ph);
      for (int i = 0; i < int'($urandom_range(10, 60)); i++) begin
        h = ($urandom_range(0, 15) == 0) ? 2'($urandom) : ph;
        step($urandom_range(0, 49) == 0, g, w, $urandom, 4'($urandom),
             $urandom_range(0, 3) != 0, h);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
